// File: rtl/maze_pkg.sv
// Shared types and constants for the maze path checker.
// Holds the grid dimension, cell count, direction and error encodings,
// checker state encoding and the (row, col) position struct.
package maze_pkg;

  localparam int DIM    = 17;
  localparam int CELLS  = DIM * DIM;
  localparam int CELL_W = $clog2(CELLS);

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    UP    = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_WALL    = 3'd1,
    ERR_BOUNDS  = 3'd2,
    ERR_GAP     = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_PROTO   = 3'd5
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_WALK,
    ST_REPORT
  } chk_state_e;

  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
  } pos_t;

endpackage

// File: rtl/maze_pos_step.sv
// Combinational single-step move on the maze grid.
// Ports:
//   pos_i      current position
//   dir_i      direction to move
//   tgt_o      target position (equals pos_i when the move leaves the grid)
//   off_grid_o 1 when the move would leave the DIM x DIM grid
module maze_pos_step
  import maze_pkg::*;
#(
  parameter int DIM = maze_pkg::DIM
) (
  input  pos_t pos_i,
  input  dir_e dir_i,
  output pos_t tgt_o,
  output logic off_grid_o
);

  localparam logic [4:0] LAST = 5'(DIM - 1);

  always_comb begin
    tgt_o      = pos_i;
    off_grid_o = 1'b0;
    unique case (dir_i)
      RIGHT: if (pos_i.col == LAST)  off_grid_o = 1'b1; else tgt_o.col = pos_i.col + 5'd1;
      DOWN:  if (pos_i.row == LAST)  off_grid_o = 1'b1; else tgt_o.row = pos_i.row + 5'd1;
      LEFT:  if (pos_i.col == 5'd0)  off_grid_o = 1'b1; else tgt_o.col = pos_i.col - 5'd1;
      UP:    if (pos_i.row == 5'd0)  off_grid_o = 1'b1; else tgt_o.row = pos_i.row - 5'd1;
      default: off_grid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/maze_path_checker.sv
// Consumer end of the MAZE link: loads the serial DIM x DIM map, then replays
// the solver's direction stream against it and emits one verdict per maze.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   in_valid_i, in_i        map bit stream, row-major, 1 = wall
//   out_valid_i, out_i      solver direction stream (dir_e encoding)
//   done_o                  one-cycle verdict pulse
//   pass_o, err_code_o      verdict, held until the next map load starts
//   steps_o                 directions accepted (saturating)
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for the first map bit
// ST_LOAD    | shifting the remaining map bits into the flop array
// ST_WAIT    | map loaded, timeout running until the first direction
// ST_WALK    | replaying contiguous directions against the map
// ST_REPORT  | done_o high for one cycle, then back to idle
module maze_path_checker
  import maze_pkg::*;
#(
  parameter int DIM     = maze_pkg::DIM,
  parameter int TIMEOUT = 3000,
  parameter int STEP_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic              in_i,
  input  logic              out_valid_i,
  input  logic [1:0]        out_i,
  output logic              done_o,
  output logic              pass_o,
  output logic [2:0]        err_code_o,
  output logic [STEP_W-1:0] steps_o
);

  localparam int CELLS_L = DIM * DIM;
  localparam int CELL_W_L = $clog2(CELLS_L);
  localparam int TMR_W   = $clog2(TIMEOUT + 1);

  chk_state_e          state_q, state_d;
  logic [CELL_W_L-1:0] cell_q, cell_d;
  pos_t                pos_q, pos_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                pass_q, pass_d;
  err_e                err_q, err_d;

  logic [CELLS_L-1:0]  map_q;
  logic                map_we;
  logic [CELL_W_L-1:0] map_widx;

  pos_t                tgt;
  logic                off_grid;
  logic [CELL_W_L-1:0] tgt_idx;
  logic                take_dir;
  logic [STEP_W-1:0]   steps_inc;

  maze_pos_step #(.DIM(DIM)) u_pos_step (
    .pos_i      (pos_q),
    .dir_i      (dir_e'(out_i)),
    .tgt_o      (tgt),
    .off_grid_o (off_grid)
  );

  // When off_grid is set the target equals the current position, so the
  // index always stays inside the map.
  assign tgt_idx   = CELL_W_L'(32'(tgt.row) * DIM + 32'(tgt.col));
  assign steps_inc = (&steps_q) ? steps_q : steps_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cell_d   = cell_q;
    pos_d    = pos_q;
    timer_d  = timer_q;
    steps_d  = steps_q;
    pass_d   = pass_q;
    err_d    = err_q;
    map_we   = 1'b0;
    map_widx = cell_q;
    take_dir = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          map_we   = 1'b1;
          map_widx = '0;
          cell_d   = CELL_W_L'(1);
          steps_d  = '0;
          pass_d   = 1'b0;
          err_d    = ERR_NONE;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (out_valid_i || !in_valid_i) begin
          err_d   = ERR_PROTO;
          state_d = ST_REPORT;
        end else begin
          map_we = 1'b1;
          if (cell_q == CELL_W_L'(CELLS_L - 1)) begin
            pos_d   = '0;
            steps_d = '0;
            timer_d = TMR_W'(TIMEOUT);
            state_d = ST_WAIT;
          end else begin
            cell_d = cell_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // timer_q counts down from TIMEOUT; zero means this is WAIT cycle
        // TIMEOUT and no direction arrived in time.
        if (timer_q == '0) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_REPORT;
        end else if (in_valid_i) begin
          err_d   = ERR_PROTO;
          state_d = ST_REPORT;
        end else if (out_valid_i) begin
          take_dir = 1'b1;
          state_d  = ST_WALK;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_WALK: begin
        if (in_valid_i) begin
          err_d   = ERR_PROTO;
          state_d = ST_REPORT;
        end else if (!out_valid_i) begin
          err_d   = ERR_GAP;
          state_d = ST_REPORT;
        end else begin
          take_dir = 1'b1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (take_dir) begin
      steps_d = steps_inc;
      if (off_grid) begin
        err_d   = ERR_BOUNDS;
        state_d = ST_REPORT;
      end else if (map_q[tgt_idx]) begin
        err_d   = ERR_WALL;
        state_d = ST_REPORT;
      end else begin
        pos_d = tgt;
        if (tgt.row == 5'(DIM - 1) && tgt.col == 5'(DIM - 1)) begin
          pass_d  = 1'b1;
          state_d = ST_REPORT;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cell_q  <= '0;
      pos_q   <= '0;
      timer_q <= '0;
      steps_q <= '0;
      pass_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      pos_q   <= pos_d;
      timer_q <= timer_d;
      steps_q <= steps_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  // Map contents need no reset; they are always rewritten before use.
  always_ff @(posedge clk_i) begin
    if (map_we) map_q[map_widx] <= in_i;
  end

  assign done_o     = (state_q == ST_REPORT);
  assign pass_o     = pass_q;
  assign err_code_o = err_q;
  assign steps_o    = steps_q;

endmodule

// File: tb/tb_maze_path_checker.sv
module tb_maze_path_checker;

  localparam int TIMEOUT = 3000;
  localparam int STEP_W  = 12;
  localparam int CELLS   = 17 * 17;
  localparam logic [1:0] R = 2'd0, D = 2'd1, L = 2'd2, U = 2'd3;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              in_valid_i = 1'b0;
  logic              in_i = 1'b0;
  logic              out_valid_i = 1'b0;
  logic [1:0]        out_i = 2'd0;
  logic              done_o;
  logic              pass_o;
  logic [2:0]        err_code_o;
  logic [STEP_W-1:0] steps_o;

  maze_path_checker #(.DIM(17), .TIMEOUT(TIMEOUT), .STEP_W(STEP_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_i        (in_i),
    .out_valid_i (out_valid_i),
    .out_i       (out_i),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .err_code_o  (err_code_o),
    .steps_o     (steps_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       pass;
    logic [2:0] err;
    int         steps;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle_n = 0;

  logic [CELLS-1:0] open_map;
  logic [CELLS-1:0] wall_map;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Pop and compare a verdict when done appears or when one is overdue.
  task automatic monitor();
    exp_t e;
    if (exp_q.size() == 0) begin
      if (done_o) chk("spurious_done", 32'(done_o), 32'd0);
    end else if (done_o || cycle_n >= exp_q[0].due) begin
      e = exp_q.pop_front();
      chk("done_seen", 32'(done_o), 32'd1);
      chk("latency", 32'(cycle_n), 32'(e.due));
      chk("pass", 32'(pass_o), 32'(e.pass));
      chk("err_code", 32'(err_code_o), 32'(e.err));
      chk("steps", 32'(steps_o), 32'(e.steps));
    end
  endtask

  // One clock: sample outputs at the falling edge, then drive the next inputs.
  task automatic cyc(input logic iv, input logic ib, input logic ov, input logic [1:0] od);
    @(negedge clk_i);
    cycle_n++;
    monitor();
    in_valid_i  = iv;
    in_i        = ib;
    out_valid_i = ov;
    out_i       = od;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic walk(input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic load_map(input logic [CELLS-1:0] m);
    for (int i = 0; i < CELLS; i++) cyc(1'b1, m[i], 1'b0, 2'd0);
  endtask

  // The deciding input was just driven; the verdict is due one clock later.
  task automatic push(input logic p, input logic [2:0] e, input int s);
    exp_t x;
    x.pass  = p;
    x.err   = e;
    x.steps = s;
    x.due   = cycle_n + 1;
    exp_q.push_back(x);
  endtask

  initial begin
    open_map = '0;
    wall_map = '0;
    wall_map[3] = 1'b1;

    // reset values
    idle(2);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pass", 32'(pass_o), 32'd0);
    chk("rst_err", 32'(err_code_o), 32'd0);
    chk("rst_steps", 32'(steps_o), 32'd0);
    rst_i = 1'b0;
    idle(2);

    // open map: 16 right, 16 down
    load_map(open_map);
    walk(R, 16);
    walk(D, 15);
    walk(D, 1);
    push(1'b1, 3'd0, 32);
    idle(3);

    // wall at (0,3)
    load_map(wall_map);
    walk(R, 2);
    walk(R, 1);
    push(1'b0, 3'd1, 3);
    idle(3);

    // bounds: first direction up
    load_map(open_map);
    walk(U, 1);
    push(1'b0, 3'd2, 1);
    idle(3);

    // bounds: 17 rights
    load_map(open_map);
    walk(R, 16);
    walk(R, 1);
    push(1'b0, 3'd2, 17);
    idle(3);

    // gap after 5 rights, later directions ignored, results held
    load_map(open_map);
    walk(R, 5);
    idle(1);
    push(1'b0, 3'd3, 5);
    walk(R, 3);
    idle(3);
    chk("hold_steps", 32'(steps_o), 32'd5);
    chk("hold_err", 32'(err_code_o), 32'd3);

    // timeout: nothing for TIMEOUT+1 WAIT cycles
    load_map(open_map);
    idle(TIMEOUT);
    idle(1);
    push(1'b0, 3'd4, 0);
    idle(3);

    // timeout boundary: first direction on WAIT cycle TIMEOUT-1 is accepted
    load_map(open_map);
    idle(TIMEOUT - 1);
    walk(R, 16);
    walk(D, 15);
    walk(D, 1);
    push(1'b1, 3'd0, 32);
    idle(3);

    // protocol: in_valid drops after 100 bits
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0);
    idle(1);
    push(1'b0, 3'd5, 0);
    idle(3);

    // protocol: in_valid together with out_valid in WALK, direction not counted
    load_map(open_map);
    walk(R, 2);
    cyc(1'b1, 1'b0, 1'b1, R);
    push(1'b0, 3'd5, 2);
    idle(3);

    // step counter saturation, then a legal exit
    load_map(open_map);
    walk(R, 1);
    for (int i = 0; i < 2100; i++) begin
      walk(L, 1);
      walk(R, 1);
    end
    walk(R, 15);
    walk(D, 15);
    walk(D, 1);
    push(1'b1, 3'd0, 4095);
    idle(3);

    // reset mid-WALK: no verdict, outputs cleared
    load_map(open_map);
    walk(R, 3);
    rst_i = 1'b1;
    #1;
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_pass", 32'(pass_o), 32'd0);
    chk("midrst_err", 32'(err_code_o), 32'd0);
    chk("midrst_steps", 32'(steps_o), 32'd0);
    idle(2);
    rst_i = 1'b0;
    idle(4);

    // back-to-back open mazes
    load_map(open_map);
    walk(R, 16);
    walk(D, 16);
    push(1'b1, 3'd0, 32);
    idle(1);
    load_map(open_map);
    chk("b2b_pass_cleared", 32'(pass_o), 32'd0);
    chk("b2b_steps_cleared", 32'(steps_o), 32'd0);
    walk(D, 16);
    walk(R, 16);
    push(1'b1, 3'd0, 32);
    idle(4);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_path_checker.md
# maze_path_checker

- Consumer end of the MAZE link: takes the same 17x17 serial map the solver takes, then the solver's 2-bit direction stream.
- Replays every step against the stored map and reports exactly one verdict per maze: pass, or the first violation with its step index.
- Sits beside the solver in self-checking benches and in the on-chip demo harness.

## Interface
Parameters:
- `DIM`, 17: maze side length; cell index = row*DIM + col.
- `TIMEOUT`, 3000: maximum cycles from end of map load to first direction.
- `STEP_W`, 12: width of the step counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  map bit valid; high for exactly DIM*DIM consecutive cycles.
- `in`  in  1  map bit, row-major from cell 0; 0 = path, 1 = wall.
- `out_valid`  in  1  solver direction valid; must stay high contiguously until the exit is reached.
- `out`  in  2  direction: 0 = right (col+1), 1 = down (row+1), 2 = left (col-1), 3 = up (row-1).
- `done`  out  1  one-cycle verdict pulse.
- `pass`  out  1  valid with `done`; 1 = exit reached legally.
- `err_code`  out  3  valid with `done`: 0 NONE, 1 WALL, 2 BOUNDS, 3 GAP, 4 TIMEOUT, 5 PROTO.
- `steps`  out  STEP_W  valid with `done`: directions accepted, including the offending one.

## Operation
- States are IDLE, LOAD, WAIT, WALK, REPORT.
- **IDLE:** `in_valid`=1 stores bit 0, clears the cell counter and goes to LOAD. `out_valid`=1 in IDLE is ignored.
- **LOAD:** one bit per cycle into a DIM*DIM flop array.
  - `in_valid` dropping before cell DIM*DIM-1 → PROTO.
  - `out_valid`=1 during LOAD → PROTO.
  - After the last bit: position = (0,0), steps = 0, timer = 0, go to WAIT.
- **WAIT:** timer counts up.
  - `out_valid`=1 → process that direction as step 1 and go to WALK.
  - Timer reaching TIMEOUT → TIMEOUT.
  - `in_valid`=1 → PROTO.
- **Per direction** (WAIT or WALK): steps += 1 (saturating), then compute the target cell.
  - Target off-grid → BOUNDS.
  - Target is a wall → WALL.
  - Otherwise position = target; if target = (DIM-1,DIM-1), go to REPORT with pass.
- **WALK:** `out_valid`=0 before the exit → GAP. `in_valid`=1 → PROTO.
- **Any violation:** go to REPORT with the error code; later inputs are ignored until IDLE.
- **REPORT:** drive `done` for one cycle, then IDLE.
- The start and exit cells are not validated; map content is trusted.
- Revisiting cells is legal.

## Timing
- Reset values: `done`=0, `pass`=0, `err_code`=0, `steps`=0, state IDLE. Map array contents are don't-care.
- Reset mid-operation aborts with no verdict pulse.
- Verdict latency: `done` rises the cycle after the sample that decides it (exit step, violating step, first low `out_valid`, or timer expiry).
- `pass`, `err_code` and `steps` are registered. They hold their value after `done` until the next LOAD starts, then clear.
- On a GAP verdict, `steps` is the count before the gap.
- Timeout boundary: first direction sampled on WAIT cycle TIMEOUT-1 is accepted; none by cycle TIMEOUT → TIMEOUT.
- Simultaneous `in_valid` and `out_valid` in WALK: PROTO wins; the direction is not counted.
- Back-to-back mazes: `in_valid` may rise the cycle after `done`.
- Step counter saturates at 2^STEP_W-1 and does not wrap.

## Structure
- Package `maze_pkg` holds:
  - `DIM` and `CELLS` constants;
  - `dir_e` (RIGHT/DOWN/LEFT/UP, 2-bit);
  - `err_e` (3-bit codes above);
  - `chk_state_e`;
  - a `pos_t` struct with 5-bit row and col.
- One combinational sub-module, `maze_pos_step`: inputs `pos_t` and `dir_e`; outputs the target `pos_t` and an `off_grid` flag.
- The top owns the map array, FSM, timer, counter and wall lookup.

## Test plan
- **Open map (all 0):** 16 rights then 16 downs, contiguous → `done` 1 cycle after the 32nd direction; `pass`=1, `err_code`=0, `steps`=32.
- **Wall hit:** cell (0,3)=1, directions right ×3 → WALL, `steps`=3, `pass`=0.
- **Bounds:** first direction up (3) → BOUNDS, `steps`=1. Separately, 17 rights on an open row → BOUNDS, `steps`=17.
- **Gap:** 5 legal rights, `out_valid` low 1 cycle, then more → GAP, `steps`=5, later directions ignored.
- **Timeout and protocol:**
  - no `out_valid` for 3000 cycles after load → TIMEOUT, `steps`=0;
  - `in_valid` dropped after 100 bits → PROTO.
- **Reset and back-to-back:** `rst` pulsed mid-WALK → no `done`, outputs 0. Then two consecutive open-map mazes → two `done` pulses, both `pass`=1.
